// File: rtl/top.sv
// FT245 one-byte loopback: read a byte while the RX FIFO has data, echo it once the TX FIFO has room.
// Optional macro ECHO_INC_EN: echo the received byte plus one (mod 256) instead of the byte itself.
`timescale 1ns/1ps
module top #(
    parameter int RD_CYCLES = 1,
    parameter int RD_GAP    = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxf,
    input  logic       txe,
    output logic       rd,
    output logic       wr,
    inout  wire  [7:0] data
);

    localparam int MAX_A   = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_CNT = (MAX_A > RD_GAP) ? MAX_A : RD_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RD_GAP - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PULSE,
        S_RD_GAP,
        S_WAIT_TX,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             rd_next, wr_next;
    logic             drive, drive_next;
    logic [7:0]       buffer, buffer_next;
    logic             full, full_next;
    logic [7:0]       tx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            rd     <= 1'b1;
            wr     <= 1'b0;
            drive  <= 1'b0;
            buffer <= 8'h00;
            full   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rd     <= rd_next;
            wr     <= wr_next;
            drive  <= drive_next;
            buffer <= buffer_next;
            full   <= full_next;
        end
    end

    // Strobes and bus enable are computed one edge ahead so every pin leaves a flop.
    always_comb begin
        state_next  = state;
        count_next  = count;
        rd_next     = rd;
        wr_next     = wr;
        drive_next  = drive;
        buffer_next = buffer;
        full_next   = full;
        case (state)
            S_IDLE: begin
                if (!rxf && !full) begin
                    state_next = S_RD_PULSE;
                    rd_next    = 1'b0;
                    count_next = '0;
                end
            end
            S_RD_PULSE: begin
                if (count == RD_LAST) begin
                    buffer_next = data;
                    full_next   = 1'b1;
                    rd_next     = 1'b1;
                    count_next  = '0;
                    state_next  = (RD_GAP == 0) ? S_WAIT_TX : S_RD_GAP;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_RD_GAP: begin
                if (count == GAP_LAST) begin
                    count_next = '0;
                    state_next = S_WAIT_TX;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_WAIT_TX: begin
                if (!txe) begin
                    state_next = S_WR_PULSE;
                    wr_next    = 1'b1;
                    drive_next = 1'b1;
                    count_next = '0;
                end
            end
            S_WR_PULSE: begin
                if (count == WR_LAST) begin
                    wr_next    = 1'b0;
                    count_next = '0;
                    state_next = S_WR_HOLD;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_WR_HOLD: begin
                drive_next = 1'b0;
                full_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                rd_next    = 1'b1;
                wr_next    = 1'b0;
                drive_next = 1'b0;
                count_next = '0;
            end
        endcase
    end

`ifdef ECHO_INC_EN
    assign tx_byte = buffer + 8'd1;
`else
    assign tx_byte = buffer;
`endif

    assign data = drive ? tx_byte : 8'bz;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the FT245 loopback: vector table, scoreboard of echoed bytes, strobe monitor.
// Compile with ECHO_INC_EN defined to check the increment-echo build.
`timescale 1ns/1ps
module tb_top;
    localparam int RD_CYCLES = 1;
    localparam int RD_GAP    = 2;
    localparam int WR_CYCLES = 2;
`ifdef ECHO_INC_EN
    localparam logic [7:0] INC = 8'd1;
`else
    localparam logic [7:0] INC = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxf = 1'b1;
    logic       txe = 1'b1;
    logic       rd, wr;
    wire  [7:0] data;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_val = 8'h00;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int wr_count = 0;
    int rd_low_len = 0;
    int wr_high_len = 0;
    logic [7:0] wr_byte = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t vectors [8];

    // Undriven bus reads back as 0xFF, so a released bus is visible in both 2- and 4-state sims.
    pullup pu_data (data);
    assign data = tb_drive ? tb_val : 8'bz;

    top #(
        .RD_CYCLES(RD_CYCLES),
        .RD_GAP   (RD_GAP),
        .WR_CYCLES(WR_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxf  (rxf),
        .txe  (txe),
        .rd   (rd),
        .wr   (wr),
        .data (data)
    );

    always #21 clk = ~clk;

    function automatic logic [7:0] echoModel(input logic [7:0] b);
        return b + INC;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Strobe widths, rd/wr overlap and echoed bytes are judged at every falling clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_low_len  = 0;
            wr_high_len = 0;
        end else begin
            checkOutput("rd_wr_overlap", 32'(!rd && wr), 32'd0);
            if (!rd) begin
                rd_low_len++;
            end else if (rd_low_len != 0) begin
                checkOutput("rd_width", 32'(rd_low_len), 32'(RD_CYCLES));
                rd_pulses++;
                rd_low_len = 0;
            end
            if (wr) begin
                if (wr_high_len == 0) wr_byte = data;
                else checkOutput("wr_data_stable", 32'(data), 32'(wr_byte));
                wr_high_len++;
            end else if (wr_high_len != 0) begin
                checkOutput("wr_width", 32'(wr_high_len), 32'(WR_CYCLES));
                checkOutput("hold_data", 32'(data), 32'(wr_byte));
                checkOutput("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) checkOutput("echo_byte", 32'(wr_byte), 32'(exp_q.pop_front()));
                wr_count++;
                wr_high_len = 0;
            end
        end
    end

    task automatic waitRdLow(input string name);
        int n = 0;
        while (rd !== 1'b0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(rd), 32'd0);
    endtask

    task automatic waitRdHigh();
        int n = 0;
        while (rd !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rd_release", 32'(rd), 32'd1);
    endtask

    task automatic waitWritesDone(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("write_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // One FT245 read: byte on the bus, rxf low ~50 ns, bus probed free while rd is low.
    task automatic applyStimulus(input logic [7:0] val, input logic [7:0] expected);
        @(posedge clk); #1;
        tb_val   = val;
        tb_drive = 1'b1;
        rxf      = 1'b0;
        exp_q.push_back(expected);
        waitRdLow("rd_start");
        #9 rxf = 1'b1;
        @(negedge clk); #1;
        tb_drive = 1'b0;
        #1 checkOutput("bus_free_during_rd", 32'(data), 32'h0000_00FF);
        tb_drive = 1'b1;
        waitRdHigh();
        tb_drive = 1'b0;
    endtask

    initial begin
        int base_rd;
        int base_wr;
        int n;

        vectors[0] = '{8'h08, echoModel(8'h08)};
        vectors[1] = '{8'h00, echoModel(8'h00)};
        vectors[2] = '{8'hFF, echoModel(8'hFF)};
        vectors[3] = '{8'h7F, echoModel(8'h7F)};
        vectors[4] = '{8'h80, echoModel(8'h80)};
        vectors[5] = '{8'hAA, echoModel(8'hAA)};
        vectors[6] = '{8'h01, echoModel(8'h01)};
        vectors[7] = '{8'hFE, echoModel(8'hFE)};

        // Reset hold, then 20 quiet cycles
        repeat (3) @(negedge clk);
        checkOutput("reset_rd", 32'(rd), 32'd1);
        checkOutput("reset_wr", 32'(wr), 32'd0);
        checkOutput("reset_data_z", 32'(data), 32'h0000_00FF);
        @(posedge clk); #5 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("quiet_rd", 32'(rd), 32'd1);
            checkOutput("quiet_wr", 32'(wr), 32'd0);
            checkOutput("quiet_data_z", 32'(data), 32'h0000_00FF);
        end
        checkOutput("quiet_no_reads", 32'(rd_pulses), 32'd0);

        // First transfer starts on the first edge after reset release
        @(posedge clk); #1 rst_n = 1'b0;
        tb_val = 8'h42; tb_drive = 1'b1; rxf = 1'b0; txe = 1'b0;
        exp_q.push_back(echoModel(8'h42));
        @(posedge clk); #5 rst_n = 1'b1;
        #1 checkOutput("pre_edge_rd_high", 32'(rd), 32'd1);
        @(posedge clk); #1;
        checkOutput("first_edge_read", 32'(rd), 32'd0);
        rxf = 1'b1;
        waitRdHigh();
        tb_drive = 1'b0;
        waitWritesDone(40);

        // Table-driven loopback vectors with the host FIFO always ready
        for (int i = 0; i < 8; i++) begin
            base_rd = rd_pulses;
            base_wr = wr_count;
            applyStimulus(vectors[i].din, vectors[i].dout);
            waitWritesDone(40);
            repeat (2) @(negedge clk);
            checkOutput("vec_one_read", 32'(rd_pulses - base_rd), 32'd1);
            checkOutput("vec_one_write", 32'(wr_count - base_wr), 32'd1);
        end

        // Back-pressure: one read only while txe is high, second read after the echo
        txe = 1'b1;
        repeat (2) @(negedge clk);
        base_rd = rd_pulses;
        base_wr = wr_count;
        @(posedge clk); #1;
        tb_val = 8'h55; tb_drive = 1'b1; rxf = 1'b0;
        exp_q.push_back(echoModel(8'h55));
        waitRdLow("bp_first_read");
        repeat (30) @(negedge clk);
        checkOutput("bp_one_read", 32'(rd_pulses - base_rd), 32'd1);
        checkOutput("bp_no_write", 32'(wr_count - base_wr), 32'd0);
        checkOutput("bp_rd_high", 32'(rd), 32'd1);
        tb_drive = 1'b0;
        exp_q.push_back(echoModel(8'h55));
        @(posedge clk); #1 txe = 1'b0;
        waitRdLow("bp_second_read");
        tb_drive = 1'b1;
        checkOutput("bp_first_written", 32'(wr_count - base_wr), 32'd1);
        rxf = 1'b1;
        waitRdHigh();
        tb_drive = 1'b0;
        waitWritesDone(60);
        repeat (2) @(negedge clk);
        checkOutput("bp_two_reads", 32'(rd_pulses - base_rd), 32'd2);
        checkOutput("bp_two_writes", 32'(wr_count - base_wr), 32'd2);

        // Reset in the middle of a write pulse
        txe = 1'b1;
        applyStimulus(8'h3C, echoModel(8'h3C));
        repeat (5) @(posedge clk);
        #1 txe = 1'b0;
        n = 0;
        while (wr !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rst_wr_started", 32'(wr), 32'd1);
        #10 rst_n = 1'b0;
        #1;
        checkOutput("rst_wr_forced", 32'(wr), 32'd0);
        checkOutput("rst_rd_forced", 32'(rd), 32'd1);
        checkOutput("rst_data_released", 32'(data), 32'h0000_00FF);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #5 rst_n = 1'b1;
        base_rd = rd_pulses;
        base_wr = wr_count;
        repeat (20) @(negedge clk);
        checkOutput("rst_no_write", 32'(wr_count - base_wr), 32'd0);
        checkOutput("rst_no_read", 32'(rd_pulses - base_rd), 32'd0);
        checkOutput("rst_bus_idle", 32'(data), 32'h0000_00FF);
        applyStimulus(8'h21, echoModel(8'h21));
        waitWritesDone(40);
        repeat (2) @(negedge clk);
        checkOutput("rst_after_write", 32'(wr_count - base_wr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
